// File: rtl/izh_pkg.sv
// izh_pkg: Q10 fixed-point constants, reset values and FSM states shared by the Izhikevich sweep controller
package izh_pkg;
  localparam int N = 20;
  localparam int Q = 10;
  localparam logic [N-1:0] V_INIT   = 20'hEFC00;
  localparam logic [N-1:0] W_INIT   = 20'hFCC00;
  localparam logic [N-1:0] V_THRESH = 20'h07800;
  localparam logic [N-1:0] A_DEF    = 20'h00014;
  localparam logic [N-1:0] B_DEF    = 20'h000CD;
  localparam logic [N-1:0] C_DEF    = 20'hEFC00;
  localparam logic [N-1:0] D_DEF    = 20'h02000;
  localparam logic [N-1:0] STEP_DEF = 20'h00400;
  localparam logic [N-1:0] K_004    = 20'h00029;
  localparam logic [N-1:0] K_5      = 20'h01400;
  localparam logic [N-1:0] K_140    = 20'h23000;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EVAL, S_WRITE, S_DONE} state_t;
endpackage

// File: rtl/izh_sweep_ctrl_if.sv
// izh_sweep_ctrl_if: sweep bus (start/step/a-d/i_flat/preload/rd_idx from sequencer; rd_v/rd_w/busy/done/spike from controller)
interface izh_sweep_ctrl_if import izh_pkg::*; #(
  parameter int NUM_NEURONS = 4,
  parameter int IDX_W = NUM_NEURONS > 1 ? $clog2(NUM_NEURONS) : 1
);
  logic                     start;
  logic [N-1:0]             step, a, b, c, d;
  logic [N*NUM_NEURONS-1:0] i_flat;
  logic                     wr_en;
  logic [IDX_W-1:0]         wr_idx;
  logic [N-1:0]             wr_v, wr_w;
  logic [IDX_W-1:0]         rd_idx;
  logic [N-1:0]             rd_v, rd_w;
  logic                     busy, done;
  logic [NUM_NEURONS-1:0]   spike;
  modport master (output start, step, a, b, c, d, i_flat, wr_en, wr_idx, wr_v, wr_w, rd_idx,
                  input rd_v, rd_w, busy, done, spike);
  modport slave  (input start, step, a, b, c, d, i_flat, wr_en, wr_idx, wr_v, wr_w, rd_idx,
                  output rd_v, rd_w, busy, done, spike);
endinterface

// File: rtl/add.sv
// add: N-bit wrap-around adder (a, b in; y out)
module add #(
  parameter int N = 20
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);
  assign y = a + b;
endmodule

// File: rtl/calc_dv.sv
// calc_dv: Izhikevich membrane increment dv = (0.04v^2 + 5v + 140 - w + i) * step (v, w, i, step in; dv out)
module calc_dv import izh_pkg::*; (
  input  logic [N-1:0] v,
  input  logic [N-1:0] w,
  input  logic [N-1:0] i,
  input  logic [N-1:0] step,
  output logic [N-1:0] dv
);
  logic [N-1:0] vv, t2, t3, nw, s1, s2, s3, s4;
  mult    #(.N(N), .Q(Q)) u_vv (.a(v),     .b(v),     .y(vv));
  mult    #(.N(N), .Q(Q)) u_t2 (.a(K_004), .b(vv),    .y(t2));
  mult    #(.N(N), .Q(Q)) u_t3 (.a(K_5),   .b(v),     .y(t3));
  negator #(.N(N))        u_nw (.a(w),                .y(nw));
  add     #(.N(N))        u_s1 (.a(t2),    .b(t3),    .y(s1));
  add     #(.N(N))        u_s2 (.a(s1),    .b(K_140), .y(s2));
  add     #(.N(N))        u_s3 (.a(s2),    .b(nw),    .y(s3));
  add     #(.N(N))        u_s4 (.a(s3),    .b(i),     .y(s4));
  mult    #(.N(N), .Q(Q)) u_dv (.a(s4),    .b(step),  .y(dv));
endmodule

// File: rtl/calc_dw.sv
// calc_dw: Izhikevich recovery increment dw = a * (b*v - w) * step (v, w, a, b, step in; dw out)
module calc_dw import izh_pkg::*; (
  input  logic [N-1:0] v,
  input  logic [N-1:0] w,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] step,
  output logic [N-1:0] dw
);
  logic [N-1:0] bv, nw, u, au;
  mult    #(.N(N), .Q(Q)) u_bv (.a(b),  .b(v),    .y(bv));
  negator #(.N(N))        u_nw (.a(w),              .y(nw));
  add     #(.N(N))        u_u  (.a(bv), .b(nw),   .y(u));
  mult    #(.N(N), .Q(Q)) u_au (.a(a),  .b(u),    .y(au));
  mult    #(.N(N), .Q(Q)) u_dw (.a(au), .b(step), .y(dw));
endmodule

// File: rtl/mult.sv
// mult: signed fixed-point multiply (a, b in; y out), product rescaled by Q fractional bits and wrapped to N bits
module mult #(
  parameter int N = 20,
  parameter int Q = 10
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);
  assign y = N'(((2*N)'($signed(a)) * (2*N)'($signed(b))) >>> Q);
endmodule

// File: rtl/negator.sv
// negator: N-bit two's complement negation (a in; y out)
module negator #(
  parameter int N = 20
) (
  input  logic [N-1:0] a,
  output logic [N-1:0] y
);
  assign y = ~a + 1'b1;
endmodule

// File: rtl/izh_sweep_ctrl.sv
// izh_sweep_ctrl: sweeps one Euler step over NUM_NEURONS Izhikevich neurons (clk, rst_n; bus.slave: start/params/currents/preload in, rd_v/rd_w/busy/done/spike out)
module izh_sweep_ctrl import izh_pkg::*; #(
  parameter int NUM_NEURONS = 4
) (
  input  logic clk,
  input  logic rst_n,
  izh_sweep_ctrl_if.slave bus
);
  localparam int IDX_W = NUM_NEURONS > 1 ? $clog2(NUM_NEURONS) : 1;
  state_t state_q, state_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic [N-1:0] step_q, step_d, a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [N-1:0] v_q [NUM_NEURONS];
  logic [N-1:0] v_d [NUM_NEURONS];
  logic [N-1:0] w_q [NUM_NEURONS];
  logic [N-1:0] w_d [NUM_NEURONS];
  logic [N-1:0] ov_q, ov_d, ow_q, ow_d, oi_q, oi_d, dv_q, dv_d, dw_q, dw_d;
  logic [NUM_NEURONS-1:0] spike_q, spike_d;
  logic [N-1:0] dv_c, dw_c, nv, nw, nwd;
  logic wr_ok, last, spk;
  calc_dv u_dv (.v(ov_q), .w(ow_q), .i(oi_q), .step(step_q), .dv(dv_c));
  calc_dw u_dw (.v(ov_q), .w(ow_q), .a(a_q), .b(b_q), .step(step_q), .dw(dw_c));
  add #(.N(N)) u_nv  (.a(ov_q), .b(dv_q), .y(nv));
  add #(.N(N)) u_nw  (.a(ow_q), .b(dw_q), .y(nw));
  add #(.N(N)) u_nwd (.a(nw),   .b(d_q),  .y(nwd));
  assign wr_ok    = 32'(bus.wr_idx) < NUM_NEURONS;
  assign last     = 32'(k_q) == NUM_NEURONS - 1;
  assign spk      = $signed(nv) >= $signed(V_THRESH);
  assign bus.rd_v  = v_q[bus.rd_idx];
  assign bus.rd_w  = w_q[bus.rd_idx];
  assign bus.busy  = state_q != S_IDLE;
  assign bus.done  = state_q == S_DONE;
  assign bus.spike = spike_q;
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    v_d     = v_q;
    w_d     = w_q;
    ov_d    = ov_q;
    ow_d    = ow_q;
    oi_d    = oi_q;
    dv_d    = dv_q;
    dw_d    = dw_q;
    spike_d = spike_q;
    case (state_q)
      S_IDLE: begin
        if (bus.wr_en && wr_ok) begin
          v_d[bus.wr_idx] = bus.wr_v;
          w_d[bus.wr_idx] = bus.wr_w;
        end
        if (bus.start) begin
          step_d  = bus.step;
          a_d     = bus.a;
          b_d     = bus.b;
          c_d     = bus.c;
          d_d     = bus.d;
          spike_d = '0;
          k_d     = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        ov_d    = v_q[k_q];
        ow_d    = w_q[k_q];
        oi_d    = bus.i_flat[k_q*N +: N];
        state_d = S_EVAL;
      end
      S_EVAL: begin
        dv_d    = dv_c;
        dw_d    = dw_c;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        v_d[k_q]     = spk ? c_q : nv;
        w_d[k_q]     = spk ? nwd : nw;
        spike_d[k_q] = spike_q[k_q] | spk;
        k_d          = k_q + 1'b1;
        state_d      = last ? S_DONE : S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      step_q  <= STEP_DEF;
      a_q     <= A_DEF;
      b_q     <= B_DEF;
      c_q     <= C_DEF;
      d_q     <= D_DEF;
      v_q     <= '{default: V_INIT};
      w_q     <= '{default: W_INIT};
      ov_q    <= '0;
      ow_q    <= '0;
      oi_q    <= '0;
      dv_q    <= '0;
      dw_q    <= '0;
      spike_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      v_q     <= v_d;
      w_q     <= w_d;
      ov_q    <= ov_d;
      ow_q    <= ow_d;
      oi_q    <= oi_d;
      dv_q    <= dv_d;
      dw_q    <= dw_d;
      spike_q <= spike_d;
    end
  end
endmodule

// File: tb/tb_izh_sweep_ctrl.sv
// tb_izh_sweep_ctrl: directed sweeps checked every cycle against an edge-count behavioural model plus literal expectations
module tb_izh_sweep_ctrl;
  import izh_pkg::*;
  localparam int NN = 4;
  localparam int IW = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  izh_sweep_ctrl_if #(.NUM_NEURONS(NN)) bus();
  izh_sweep_ctrl #(.NUM_NEURONS(NN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int tests = 0;
  int fails = 0;
  logic [N-1:0] mv [NN];
  logic [N-1:0] mw [NN];
  logic [N-1:0] mi [NN];
  logic [NN-1:0] msp;
  logic [N-1:0] ms, ma, mb, mc, md;
  bit act = 0;
  bit chk_en = 0;
  int n = 0;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask
  function automatic logic [N-1:0] mul(input logic [N-1:0] x, input logic [N-1:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return N'(p >>> Q);
  endfunction
  task automatic commit(input int k);
    logic [N-1:0] v, w, dv, dw, nv, nw;
    v  = mv[k];
    w  = mw[k];
    dv = mul(ms, mul(K_004, mul(v, v)) + mul(K_5, v) + K_140 - w + mi[k]);
    dw = mul(mul(ma, mul(mb, v) - w), ms);
    nv = v + dv;
    nw = w + dw;
    if ($signed(nv) >= $signed(V_THRESH)) begin
      mv[k]  = mc;
      mw[k]  = nw + md;
      msp[k] = 1'b1;
    end else begin
      mv[k] = nv;
      mw[k] = nw;
    end
  endtask
  // edges are counted from the accepting edge; neuron k loads at 3k+1 and commits at 3k+3
  task automatic model_step();
    if (!rst_n) begin
      act = 0;
      n   = 0;
      msp = '0;
      for (int i = 0; i < NN; i++) begin
        mv[i] = V_INIT;
        mw[i] = W_INIT;
      end
      ms = STEP_DEF; ma = A_DEF; mb = B_DEF; mc = C_DEF; md = D_DEF;
      chk_en = 1;
    end else if (act) begin
      n++;
      if (n % 3 == 1 && n < 3*NN) mi[n/3] = bus.i_flat[(n/3)*N +: N];
      if (n % 3 == 0) commit(n/3 - 1);
      if (n == 3*NN + 1) act = 0;
    end else begin
      if (bus.wr_en && int'(bus.wr_idx) < NN) begin
        mv[bus.wr_idx] = bus.wr_v;
        mw[bus.wr_idx] = bus.wr_w;
      end
      if (bus.start) begin
        ms = bus.step; ma = bus.a; mb = bus.b; mc = bus.c; md = bus.d;
        msp = '0;
        act = 1;
        n   = 0;
      end
    end
  endtask
  initial forever begin
    @(posedge clk);
    model_step();
  end
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("busy", 32'(bus.busy), 32'(act));
      chk("done", 32'(bus.done), 32'(act && n == 3*NN));
      chk("spike", 32'(bus.spike), 32'(msp));
      chk("rd_v", 32'(bus.rd_v), 32'(mv[bus.rd_idx]));
      chk("rd_w", 32'(bus.rd_w), 32'(mw[bus.rd_idx]));
    end
  end
  task automatic wr(input int idx, input logic [N-1:0] v, input logic [N-1:0] w);
    bus.wr_en = 1'b1; bus.wr_idx = IW'(idx); bus.wr_v = v; bus.wr_w = w;
    @(posedge clk); #2;
    bus.wr_en = 1'b0;
  endtask
  task automatic peek(input string nm, input int idx, input logic [N-1:0] ev, input logic [N-1:0] ew);
    bus.rd_idx = IW'(idx);
    #1;
    chk({nm, "_v"}, 32'(bus.rd_v), 32'(ev));
    chk({nm, "_w"}, 32'(bus.rd_w), 32'(ew));
  endtask
  task automatic sweep(input int pulse_c, input int rst_c, input logic [N*NN-1:0] imid,
                       output int dc, output int da);
    dc = 0;
    da = -1;
    bus.start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #2;
      bus.start  = (c == pulse_c);
      bus.wr_en  = (c == pulse_c);
      rst_n      = (c != rst_c);
      bus.rd_idx = IW'(c);
      if (c == 6) bus.i_flat = imid;
      @(negedge clk);
      if (bus.done) begin
        dc++;
        da = c;
      end
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask
  initial begin
    int dc, da;
    bus.start = 0; bus.step = 0; bus.a = A_DEF; bus.b = B_DEF; bus.c = C_DEF; bus.d = D_DEF;
    bus.i_flat = '0; bus.wr_en = 0; bus.wr_idx = 0; bus.wr_v = 0; bus.wr_w = 0; bus.rd_idx = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < NN; i++) peek("rst", i, 20'hEFC00, 20'hFCC00);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_spike", 32'(bus.spike), 0);
    wr(2, 20'h07800, 20'h00000);
    sweep(0, 0, '0, dc, da);
    chk("thr_done_cnt", dc, 1);
    chk("thr_done_at", da, 13);
    chk("thr_spike", 32'(bus.spike), 32'h4);
    peek("thr_n2", 2, 20'hEFC00, 20'h02000);
    peek("thr_n0", 0, 20'hEFC00, 20'hFCC00);
    peek("thr_n3", 3, 20'hEFC00, 20'hFCC00);
    wr(1, 20'h077FF, 20'hFCC00);
    sweep(0, 0, '0, dc, da);
    chk("sub_spike", 32'(bus.spike), 0);
    peek("sub_n1", 1, 20'h077FF, 20'hFCC00);
    bus.wr_idx = 2'd3; bus.wr_v = 20'h07800; bus.wr_w = 20'h0;
    sweep(5, 0, '0, dc, da);
    chk("busy_done_cnt", dc, 1);
    chk("busy_done_at", da, 13);
    chk("busy_spike", 32'(bus.spike), 0);
    peek("busy_wr_n3", 3, 20'hEFC00, 20'hFCC00);
    wr(0, 20'h07800, 20'h00000);
    sweep(0, 7, '0, dc, da);
    chk("mrst_done_cnt", dc, 0);
    chk("mrst_busy", 32'(bus.busy), 0);
    chk("mrst_spike", 32'(bus.spike), 0);
    for (int i = 0; i < NN; i++) peek("mrst", i, 20'hEFC00, 20'hFCC00);
    bus.wr_en = 1'b1; bus.wr_idx = 2'd0; bus.wr_v = 20'h07800; bus.wr_w = 20'h0;
    sweep(0, 0, '0, dc, da);
    chk("simul_spike0", 32'(bus.spike[0]), 1);
    peek("simul_n0", 0, 20'hEFC00, 20'h02000);
    wr(0, 20'h07400, 20'h00000);
    wr(2, 20'h0A000, 20'h00800);
    bus.step = 20'h00033; bus.a = 20'h00020; bus.b = 20'h00100; bus.c = 20'hF3400; bus.d = 20'h01000;
    bus.i_flat = {20'h01000, 20'h02000, 20'h03000, 20'h0A000};
    sweep(0, 0, {20'hFD000, 20'h05000, 20'h00400, 20'h00000}, dc, da);
    chk("euler_done_cnt", dc, 1);
    wr(1, 20'h00400, 20'h00000);
    wr(3, 20'h00000, 20'h00000);
    bus.step = 20'h00400; bus.a = 20'h00400; bus.b = 20'h00400; bus.c = C_DEF; bus.d = D_DEF;
    bus.i_flat = {20'h00000, 20'h00000, 20'hDBC00, 20'h00000};
    sweep(0, 0, {20'h00000, 20'h00000, 20'hDBC00, 20'h00000}, dc, da);
    chk("unit_spike1", 32'(bus.spike[1]), 0);
    chk("unit_spike3", 32'(bus.spike[3]), 1);
    peek("unit_n1", 1, 20'h00429, 20'h00400);
    peek("unit_n3", 3, 20'hEFC00, 20'h02000);
    @(posedge clk); #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
